// File: rtl/ball_mover.sv
// Breakout ball motion: advances the ball one STEP per tick pulse, reflects it
// off the side and top walls, the paddle and bricks, and reports a ball lost
// through the bottom edge.
module ball_mover #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int STEP      = 1,
  parameter int PADDLE_Y  = 448,
  parameter int PADDLE_W  = 64,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       moving,
  output logic       lost
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_LOST
  } state_t;

  // All position arithmetic is done 11 bits wide so sums never wrap.
  localparam logic [10:0] C_STEP   = 11'(STEP);
  localparam logic [10:0] C_BALL   = 11'(BALL_SIZE);
  localparam logic [10:0] C_XMAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] C_YMAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] C_PADY   = 11'(PADDLE_Y);
  localparam logic [10:0] C_PADW   = 11'(PADDLE_W);
  localparam logic [9:0]  C_XMAX10 = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  C_PADTOP = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]  C_XINIT  = 10'(X_INIT);
  localparam logic [9:0]  C_YINIT  = 10'(Y_INIT);

  state_t      r_state, w_state_nx;
  logic [9:0]  r_x, r_y, w_x_nx, w_y_nx;
  logic        r_dx, r_dy, w_dx_nx, w_dy_nx;
  logic        r_pend, w_pend_nx;
  logic        r_lost, w_lost_nx;
  logic        r_moving;

  logic [10:0] w_x, w_y, w_px;
  logic [10:0] w_xp, w_xm, w_yp, w_ym, w_ybot, w_ybot_step;
  logic        w_overlap, w_dy_eff;

  assign w_x         = {1'b0, r_x};
  assign w_y         = {1'b0, r_y};
  assign w_px        = {1'b0, paddle_x};
  assign w_xp        = w_x + C_STEP;
  assign w_xm        = w_x - C_STEP;
  assign w_yp        = w_y + C_STEP;
  assign w_ym        = w_y - C_STEP;
  assign w_ybot      = w_y + C_BALL;
  assign w_ybot_step = w_ybot + C_STEP;
  assign w_overlap   = (w_x + C_BALL > w_px) && (w_x < w_px + C_PADW);
  // A pending or same-cycle brick hit flips vertical direction before the step.
  assign w_dy_eff    = r_dy ^ (r_pend | brick_hit);

  // State, position, direction and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= C_XINIT;
      r_y      <= C_YINIT;
      r_dx     <= 1'b1;
      r_dy     <= 1'b0;
      r_pend   <= 1'b0;
      r_lost   <= 1'b0;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_x      <= w_x_nx;
      r_y      <= w_y_nx;
      r_dx     <= w_dx_nx;
      r_dy     <= w_dy_nx;
      r_pend   <= w_pend_nx;
      r_lost   <= w_lost_nx;
      r_moving <= (w_state_nx == S_MOVE);
    end
  end

  // Next-state, movement and reflection logic.
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_dx_nx    = r_dx;
    w_dy_nx    = r_dy;
    w_pend_nx  = r_pend;
    w_lost_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_x_nx    = C_XINIT;
        w_y_nx    = C_YINIT;
        w_dx_nx   = 1'b1;
        w_dy_nx   = 1'b0;
        w_pend_nx = 1'b0;
        if (launch) w_state_nx = S_MOVE;
      end
      S_MOVE: begin
        if (!tick) begin
          if (brick_hit) w_pend_nx = 1'b1;
        end else begin
          w_pend_nx = 1'b0;
          w_dy_nx   = w_dy_eff;
          // Horizontal step with side-wall reflection.
          if (r_dx) begin
            if (w_xp >= C_XMAX) begin
              w_x_nx  = C_XMAX10;
              w_dx_nx = 1'b0;
            end else begin
              w_x_nx = w_xp[9:0];
            end
          end else if (w_x <= C_STEP) begin
            w_x_nx  = '0;
            w_dx_nx = 1'b1;
          end else begin
            w_x_nx = w_xm[9:0];
          end
          // Vertical step: top wall, paddle, bottom loss.
          if (!w_dy_eff) begin
            if (w_y <= C_STEP) begin
              w_y_nx  = '0;
              w_dy_nx = 1'b1;
            end else begin
              w_y_nx = w_ym[9:0];
            end
          end else if ((w_ybot <= C_PADY) && (w_ybot_step >= C_PADY) && w_overlap) begin
            w_y_nx  = C_PADTOP;
            w_dy_nx = 1'b0;
          end else if (w_yp >= C_YMAX) begin
            // Loss overrides the x step; the ball is parked at serve position.
            w_state_nx = S_LOST;
            w_lost_nx  = 1'b1;
            w_x_nx     = C_XINIT;
            w_y_nx     = C_YINIT;
            w_dx_nx    = 1'b1;
            w_dy_nx    = 1'b0;
          end else begin
            w_y_nx = w_yp[9:0];
          end
        end
      end
      S_LOST: begin
        w_state_nx = S_IDLE;
        w_x_nx     = C_XINIT;
        w_y_nx     = C_YINIT;
        w_dx_nx    = 1'b1;
        w_dy_nx    = 1'b0;
        w_pend_nx  = 1'b0;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign ball_x = r_x;
  assign ball_y = r_y;
  assign dir_x  = r_dx;
  assign dir_y  = r_dy;
  assign moving = r_moving;
  assign lost   = r_lost;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: serve, brick flips, paddle hit/miss edges,
// bottom loss, right/top wall reflection and asynchronous reset.
module tb_ball_mover;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       launch;
  logic [9:0] paddle_x;
  logic       brick_hit;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       moving;
  logic       lost;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  ball_mover dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .launch   (launch),
    .paddle_x (paddle_x),
    .brick_hit(brick_hit),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .moving   (moving),
    .lost     (lost)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Full ball state check.
  task automatic check_ball(input string tag, input int x, input int y,
                            input logic dx, input logic dy, input logic mv, input logic ls);
    check({tag, ".x"},      16'(ball_x), 16'(x));
    check({tag, ".y"},      16'(ball_y), 16'(y));
    check({tag, ".dir_x"},  16'(dir_x),  16'(dx));
    check({tag, ".dir_y"},  16'(dir_y),  16'(dy));
    check({tag, ".moving"}, 16'(moving), 16'(mv));
    check({tag, ".lost"},   16'(lost),   16'(ls));
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic t, input logic b, input logic l);
    tick      = t;
    brick_hit = b;
    launch    = l;
    @(posedge clock);
    #1;
    tick      = 1'b0;
    brick_hit = 1'b0;
    launch    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    tick      = 1'b0;
    launch    = 1'b0;
    brick_hit = 1'b0;
    paddle_x  = 10'd0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_ball("reset", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // IDLE ignores tick and brick_hit.
    cyc(1'b1, 1'b1, 1'b0);
    check_ball("idle_tick", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);

    // Serve and three ticks.
    cyc(1'b0, 1'b0, 1'b1);
    check_ball("launch", 316, 400, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(3);
    check_ball("serve3", 319, 397, 1'b1, 1'b0, 1'b1, 1'b0);

    // Two brick hits between ticks count as one flip.
    cyc(1'b0, 1'b1, 1'b0);
    check("hit_no_tick.dir_y", 16'(dir_y), 16'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_ball("double_hit", 320, 398, 1'b1, 1'b1, 1'b1, 1'b0);

    // Hit coincident with tick flips that same tick.
    cyc(1'b1, 1'b1, 1'b0);
    check_ball("coincident", 321, 397, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check_ball("flip_down", 322, 398, 1'b1, 1'b1, 1'b1, 1'b0);

    // Descend to the paddle window.
    ticks(41);
    check_ball("pre_paddle", 363, 439, 1'b1, 1'b1, 1'b1, 1'b0);
    // ball_x == paddle_x+PADDLE_W: no overlap, keeps falling.
    paddle_x = 10'd299;
    ticks(1);
    check_ball("paddle_miss", 364, 440, 1'b1, 1'b1, 1'b1, 1'b0);
    // ball_x == paddle_x+PADDLE_W-1: overlap, bounce.
    paddle_x = 10'd301;
    ticks(1);
    check_ball("paddle_hit", 365, 440, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flip down with the paddle away, fall to the bottom.
    paddle_x = 10'd0;
    cyc(1'b1, 1'b1, 1'b0);
    check_ball("fall_start", 366, 441, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(30);
    check_ball("bottom", 396, 471, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(1);
    check_ball("lost", 316, 400, 1'b1, 1'b0, 1'b0, 1'b1);
    // launch ignored during LOST.
    cyc(1'b0, 1'b0, 1'b1);
    check_ball("after_lost", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_ball("idle_again", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);

    // Right wall.
    cyc(1'b0, 1'b0, 1'b1);
    ticks(315);
    check_ball("pre_wall", 631, 85, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(1);
    check_ball("wall_hit", 632, 84, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    check_ball("wall_leave", 631, 83, 1'b0, 1'b0, 1'b1, 1'b0);

    // Top wall.
    ticks(82);
    check_ball("pre_top", 549, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    check_ball("top_hit", 548, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_ball("async_reset", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check_ball("post_reset_tick", 316, 400, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
